// File: rtl/ex_mem_stage_buffer_pkg.sv
// Shared definitions for the EX/MEM stage buffer: default widths, FSM encoding,
// control-bundle bit positions and the overflow-trap helper.
package ex_mem_stage_buffer_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_e;

    localparam int CTL_MEM_READ   = 0;
    localparam int CTL_MEM_WRITE  = 1;
    localparam int CTL_REG_WRITE  = 2;
    localparam int CTL_MEM_TO_REG = 3;
    localparam int CTL_EXCEPTION  = 4;
    localparam int CTL_WIDTH      = 5;

    function automatic logic [CTL_WIDTH-1:0] pack_ctl(
        input logic mem_read,
        input logic mem_write,
        input logic reg_write,
        input logic mem_to_reg
    );
        logic [CTL_WIDTH-1:0] ctl;
        ctl                 = '0;
        ctl[CTL_MEM_READ]   = mem_read;
        ctl[CTL_MEM_WRITE]  = mem_write;
        ctl[CTL_REG_WRITE]  = reg_write;
        ctl[CTL_MEM_TO_REG] = mem_to_reg;
        return ctl;
    endfunction

    // An overflowing result must not update architectural state.
    function automatic logic [CTL_WIDTH-1:0] trap_ctl(
        input logic [CTL_WIDTH-1:0] ctl,
        input logic                 ovf
    );
        logic [CTL_WIDTH-1:0] res;
        res = ctl;
        if (ovf) begin
            res[CTL_REG_WRITE] = 1'b0;
            res[CTL_MEM_WRITE] = 1'b0;
            res[CTL_EXCEPTION] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ex_mem_stage_buffer_pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous active-high clear.
module pipe_payload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_stage_buffer.sv
// Two-entry elastic buffer between execute and memory stages (head + skid).
// Build option: OVERFLOW_TRAP_EN turns an ALU overflow into a squashed, flagged entry.
module ex_mem_stage_buffer
    import ex_mem_stage_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_overflow,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      reg_write,
    input  logic                      mem_to_reg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_zero,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_dest_reg,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_reg_write,
    output logic                      out_mem_to_reg,
    output logic                      out_exception,
    output logic [1:0]                state_dbg
);

    localparam int DEST_LSB  = CTL_WIDTH;
    localparam int STORE_LSB = DEST_LSB + REG_ADDR_WIDTH;
    localparam int ZERO_BIT  = STORE_LSB + DATA_WIDTH;
    localparam int RES_LSB   = ZERO_BIT + 1;
    localparam int PAY_W     = RES_LSB + DATA_WIDTH;

    // Handshake: a beat transfers on a side only when valid and ready are both
    // high at the rising edge; in_ready is registered and low only in FULL, and
    // a flush in the same cycle discards any input beat and drops both entries.
    buf_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       accept, take, pop;
    logic       head_load, skid_load, head_from_skid;

    logic [CTL_WIDTH-1:0] in_ctl;
    logic [PAY_W-1:0]     in_payload, head_d, head_q, skid_q;
    logic [CTL_WIDTH-1:0] head_ctl;

    assign accept = in_valid & in_ready_q;
    assign take   = accept & ~flush;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (take) state_d = ST_ONE;
                ST_ONE: begin
                    if (take && !pop)      state_d = ST_FULL;
                    else if (pop && !take) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_FULL);

    always_comb begin
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: head_load = take;
            ST_ONE: begin
                head_load = take & pop;
                skid_load = take & ~pop;
            end
            ST_FULL: begin
                head_load      = pop & ~flush;
                head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign state_dbg = state_q;

`ifdef OVERFLOW_TRAP_EN
    assign in_ctl = trap_ctl(pack_ctl(mem_read, mem_write, reg_write, mem_to_reg), alu_overflow);
`else
    assign in_ctl = pack_ctl(mem_read, mem_write, reg_write, mem_to_reg);
`endif

    assign in_payload = {alu_result, alu_zero, store_data, dest_reg, in_ctl};
    assign head_d     = head_from_skid ? skid_q : in_payload;

    pipe_payload_reg #(.WIDTH(PAY_W)) u_head (
        .clk    (clk),
        .rst    (reset),
        .load_i (head_load),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    pipe_payload_reg #(.WIDTH(PAY_W)) u_skid (
        .clk    (clk),
        .rst    (reset),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_q)
    );

    assign head_ctl       = head_q[CTL_WIDTH-1:0];
    assign out_result     = head_q[RES_LSB +: DATA_WIDTH];
    assign out_zero       = head_q[ZERO_BIT];
    assign out_store_data = head_q[STORE_LSB +: DATA_WIDTH];
    assign out_dest_reg   = head_q[DEST_LSB +: REG_ADDR_WIDTH];

    // Controls are qualified by out_valid so a stale head never writes.
    assign out_mem_read   = out_valid & head_ctl[CTL_MEM_READ];
    assign out_mem_write  = out_valid & head_ctl[CTL_MEM_WRITE];
    assign out_reg_write  = out_valid & head_ctl[CTL_REG_WRITE];
    assign out_mem_to_reg = out_valid & head_ctl[CTL_MEM_TO_REG];

`ifdef OVERFLOW_TRAP_EN
    assign out_exception  = out_valid & head_ctl[CTL_EXCEPTION];
`else
    assign out_exception  = 1'b0;
    logic unused_ovf;
    assign unused_ovf = alu_overflow ^ head_ctl[CTL_EXCEPTION];
`endif

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Directed bench for ex_mem_stage_buffer: vector table plus reset sequences.
module tb_ex_mem_stage_buffer;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b10;
`ifdef OVERFLOW_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic          clk, reset, flush, in_valid, in_ready;
    logic [DW-1:0] alu_result, store_data;
    logic          alu_zero, alu_overflow;
    logic [RW-1:0] dest_reg;
    logic          mem_read, mem_write, reg_write, mem_to_reg;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_result, out_store_data;
    logic          out_zero;
    logic [RW-1:0] out_dest_reg;
    logic          out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
    logic          out_exception;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    ex_mem_stage_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .store_data     (store_data),
        .dest_reg       (dest_reg),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_zero       (out_zero),
        .out_store_data (out_store_data),
        .out_dest_reg   (out_dest_reg),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_exception  (out_exception),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          iv;
        logic          ordy;
        logic          fl;
        logic          regw;
        logic          memw;
        logic          ovf;
        logic [DW-1:0] res;
        logic [1:0]    e_state;
        logic          e_valid;
        logic          e_ready;
        logic [DW-1:0] e_res;
        logic          e_regw;
        logic          e_memw;
        logic          e_exc;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic regw, input logic memw, input logic ovf,
                                input logic [DW-1:0] res, input logic [1:0] st,
                                input logic v, input logic r, input logic [DW-1:0] er,
                                input logic eregw, input logic ememw, input logic eexc);
        vec_t x;
        x.iv = iv; x.ordy = ordy; x.fl = fl; x.regw = regw; x.memw = memw; x.ovf = ovf;
        x.res = res; x.e_state = st; x.e_valid = v; x.e_ready = r; x.e_res = er;
        x.e_regw = eregw; x.e_memw = ememw; x.e_exc = eexc;
        return x;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Side fields are derived from the result so one number identifies a whole entry.
    task automatic drive(input vec_t v);
        in_valid     = v.iv;
        out_ready    = v.ordy;
        flush        = v.fl;
        alu_result   = v.res;
        alu_zero     = v.res[2];
        store_data   = ~v.res;
        dest_reg     = v.res[RW-1:0];
        mem_read     = v.res[0];
        mem_to_reg   = v.res[1];
        reg_write    = v.regw;
        mem_write    = v.memw;
        alu_overflow = v.ovf;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d_state", i), DW'(state_dbg), DW'(v.e_state));
        check($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(v.e_valid));
        check($sformatf("v%0d_in_ready", i), DW'(in_ready), DW'(v.e_ready));
        check($sformatf("v%0d_result", i), out_result, v.e_res);
        check($sformatf("v%0d_store", i), out_store_data, ~v.e_res);
        check($sformatf("v%0d_dest", i), DW'(out_dest_reg), DW'(v.e_res[RW-1:0]));
        check($sformatf("v%0d_zero", i), DW'(out_zero), DW'(v.e_res[2]));
        check($sformatf("v%0d_mem_read", i), DW'(out_mem_read), DW'(v.e_valid & v.e_res[0]));
        check($sformatf("v%0d_mem_to_reg", i), DW'(out_mem_to_reg), DW'(v.e_valid & v.e_res[1]));
        check($sformatf("v%0d_reg_write", i), DW'(out_reg_write), DW'(v.e_regw));
        check($sformatf("v%0d_mem_write", i), DW'(out_mem_write), DW'(v.e_memw));
        check($sformatf("v%0d_exception", i), DW'(out_exception), DW'(v.e_exc));
    endtask

    task automatic idle_inputs();
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, S_EMPTY, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, DW'(out_valid), '0);
        check({tag, "_in_ready"}, DW'(in_ready), '0);
        check({tag, "_state"}, DW'(state_dbg), DW'(S_EMPTY));
        check({tag, "_result"}, out_result, '0);
        check({tag, "_store"}, out_store_data, '0);
        check({tag, "_dest"}, DW'(out_dest_reg), '0);
        check({tag, "_ctl"}, DW'({out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_exception}), '0);
    endtask

    initial begin
        //             iv ordy fl  rw  mw  ovf res         state    v  rdy exp_res     rw     mw     exc
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 32'h1,        S_ONE,   1, 1, 32'h1,        0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 32'h2,        S_ONE,   1, 1, 32'h2,        0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 32'h3,        S_ONE,   1, 1, 32'h3,        0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 32'h4,        S_ONE,   1, 1, 32'h4,        0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'h4,        0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 32'hA,        S_ONE,   1, 1, 32'hA,        0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 32'hB,        S_FULL,  1, 0, 32'hA,        0, 0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 32'hC,        S_FULL,  1, 0, 32'hA,        0, 0, 0);
        vecs[8]  = mk(1, 1, 0, 0, 0, 0, 32'hC,        S_ONE,   1, 1, 32'hB,        0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 0, 32'hC,        S_ONE,   1, 1, 32'hC,        0, 0, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'hC,        0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 32'h11,       S_ONE,   1, 1, 32'h11,       0, 0, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 32'h12,       S_FULL,  1, 0, 32'h11,       0, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 0, 0, 32'hD,        S_EMPTY, 0, 1, 32'h11,       0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'h11,       0, 0, 0);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 32'h21,       S_ONE,   1, 1, 32'h21,       0, 0, 0);
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 32'hD,        S_EMPTY, 0, 1, 32'h21,       0, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'h21,       0, 0, 0);
        vecs[18] = mk(1, 0, 0, 1, 1, 0, 32'h31,       S_ONE,   1, 1, 32'h31,       1, 1, 0);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'h31,       0, 0, 0);
        vecs[20] = mk(1, 0, 0, 1, 1, 1, 32'h41,       S_ONE,   1, 1, 32'h41,       !TRAP, !TRAP, TRAP);
        vecs[21] = mk(0, 1, 0, 0, 0, 0, 32'h0,        S_EMPTY, 0, 1, 32'h41,       0, 0, 0);

        reset = 1'b1;
        idle_inputs();
        #12;
        check_reset_outputs("por");

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_in_ready_before_edge", DW'(in_ready), '0);
        @(posedge clk);
        #1;
        check("release_in_ready_after_edge", DW'(in_ready), 32'h1);
        check("release_state", DW'(state_dbg), DW'(S_EMPTY));

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Reset asserted mid-cycle while FULL must clear everything immediately.
        drive(mk(1, 0, 0, 1, 1, 0, 32'h51, S_EMPTY, 0, 0, '0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(mk(1, 0, 0, 1, 1, 0, 32'h52, S_EMPTY, 0, 0, '0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("mid_full_state", DW'(state_dbg), DW'(S_FULL));
        check("mid_full_head", out_result, 32'h51);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready_after_edge", DW'(in_ready), 32'h1);
        check("mid_rst_out_valid_after_edge", DW'(out_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
